banked_ram: RTL
===============

# banked_ram

Parametrised, banked single-port memory with a registered valid/ready request interface, one-cycle read latency, out-of-range detection and hardware zero-initialisation. Successor to the fixed 12-bit/15-bank RAM: bank count, bank depth and data width are generic, unpopulated bank slots are flagged instead of silently aliasing, and contents are guaranteed zero after reset or clear. Sits between the CPU data path and the memory-mapped region as the main data store.

## Interface
- DATA_W, 16, word width.
- WORD_ADDR_W, 8, per-bank word address bits; bank depth = 2^WORD_ADDR_W.
- ADDR_W, 12, total address bits; bank select = req_addr[ADDR_W-1:WORD_ADDR_W].
- NUM_BANKS, 15, populated banks; legal range 1 .. 2^(ADDR_W-WORD_ADDR_W).

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous request to re-zero all contents.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  request targeted bank index ≥ NUM_BANKS.
- init_busy  out  1  zero-initialisation in progress.

## Operation
- FSM states: INIT, RUN. rst → INIT, init counter = 0.
- INIT: each cycle writes 0 to word init counter in all banks in parallel; counter increments; when counter = 2^WORD_ADDR_W-1, that word is written and state → RUN. req_ready = 0, init_busy = 1.
- RUN: req_ready = 1, init_busy = 0. clear = 1 → INIT, counter = 0, at the next edge.
- Accepted write, in range: bank[sel][word] ← req_wdata at the accepting edge; response next cycle with rsp_rdata = 0, rsp_err = 0.
- Accepted read, in range: response next cycle, rsp_rdata = stored word, rsp_err = 0.
- Out-of-range (sel ≥ NUM_BANKS): write dropped, no bank touched; response next cycle with rsp_rdata = 0, rsp_err = 1.
- Exactly one response per accepted request, in order.
- clear with accepted request in the same cycle: request executes and responds normally; INIT starts at the same edge.
- clear during INIT: ignored.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_busy 1.
- Init duration: exactly 2^WORD_ADDR_W cycles from first edge after rst release (or after clear edge) to req_ready = 1.
- Read latency: 1 cycle, accept edge N → rsp_valid high during cycle N+1.
- Write then read same address on consecutive edges returns new data.
- Full throughput: one request per cycle in RUN.
- rst asserted mid-operation: outputs go to reset values immediately; pending response is discarded; init restarts from word 0.
- Bank select for response mux is registered with the request so it aligns with the synchronous bank read.

## Structure
- Package banked_ram_pkg: FSM state enum (INIT, RUN), derived localparams SEL_W = ADDR_W-WORD_ADDR_W, DEPTH = 2^WORD_ADDR_W, and an elaboration-time check NUM_BANKS ≤ 2^SEL_W.
- Sub-module ram_bank: one bank, DEPTH × DATA_W, synchronous write with write enable, synchronous registered read. Instantiated NUM_BANKS times through a generate loop. No reset on the storage array.
- Top: FSM, init counter, write-enable decode (init overrides request), registered sel/err/valid, output mux.

## Test plan
- Release rst, hold req_valid = 1 -> req_ready rises after exactly 256 cycles; read of 0x000, 0x5FF and 0xEFF all return 0x0000, rsp_err = 0.
- Write 0x1234 to 0x3A7, read 0x3A7 on next cycle -> rsp_valid the cycle after, rsp_rdata = 0x1234; read 0x2A7 -> 0x0000 (no aliasing across banks).
- Write 0xBEEF to 0xF10, then read 0xF10 -> both responses rsp_err = 1, read rsp_rdata = 0x0000; 0xE10 is unchanged.
- Back-to-back stream of 16 writes, then 16 reads across all banks -> one response per cycle, in order, with matching data.
- Write 0xAAAA to 0x001, assert clear with a read of 0x001 in the same cycle -> read returns 0xAAAA, then init_busy = 1 for 256 cycles, then read of 0x001 returns 0x0000.
- Assert rst during a read's accept cycle -> no rsp_valid follows; outputs return to reset values and init restarts.

Source files
------------

// File: rtl/banked_ram_pkg.sv
// Shared types and default geometry for the banked RAM: FSM state encoding,
// default parameters and the bank-count legality check.
package banked_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WORD_ADDR_W = 8;
    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_NUM_BANKS   = 15;

    localparam int SEL_W = DEF_ADDR_W - DEF_WORD_ADDR_W;
    localparam int DEPTH = 2 ** DEF_WORD_ADDR_W;

    // A bank count is legal when every populated bank has a select code.
    function automatic bit banks_fit(input int num_banks, input int sel_w);
        return (num_banks >= 1) && (num_banks <= (1 << sel_w));
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One storage bank: synchronous write with enable, registered synchronous read
// (read-during-write returns the previous contents).
module ram_bank
    import banked_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_WORD_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto block RAM; the top zeroes it
    // through the ordinary write port during INIT instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/banked_ram.sv
// Banked single-port RAM: valid/ready request port, one-cycle read latency,
// out-of-range bank flagging and hardware zero-fill after reset or clear.
module banked_ram
    import banked_ram_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WORD_ADDR_W = DEF_WORD_ADDR_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_BANKS   = DEF_NUM_BANKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int BANK_SEL_W = ADDR_W - WORD_ADDR_W;
    localparam logic [BANK_SEL_W:0] NUM_BANKS_W = (BANK_SEL_W + 1)'(NUM_BANKS);

    if (!banks_fit(NUM_BANKS, BANK_SEL_W)) begin : g_bad_cfg
        $error("banked_ram: NUM_BANKS must lie in 1 .. 2**(ADDR_W-WORD_ADDR_W)");
    end

    state_t                 state, state_nxt;
    logic [WORD_ADDR_W-1:0] init_cnt, init_cnt_nxt;
    logic                   accept;
    logic [BANK_SEL_W-1:0]  sel;
    logic                   in_range;
    logic [WORD_ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0]      bank_wdata;
    logic [NUM_BANKS-1:0]   bank_we;
    logic [DATA_W-1:0]      bank_q [NUM_BANKS];
    logic [BANK_SEL_W-1:0]  rsp_sel;
    logic                   rsp_rd;

    assign req_ready = (state == RUN);
    assign init_busy = (state == INIT);
    assign accept    = req_valid && req_ready;
    assign sel       = req_addr[ADDR_W-1:WORD_ADDR_W];
    // One extra bit so NUM_BANKS == 2**BANK_SEL_W is representable.
    assign in_range  = {1'b0, sel} < NUM_BANKS_W;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            INIT: begin
                init_cnt_nxt = init_cnt + 1'b1;
                if (init_cnt == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_nxt    = INIT;
                    init_cnt_nxt = '0;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // Zero-fill owns the bank ports while INIT; requests cannot be accepted then.
    always_comb begin
        bank_addr  = req_addr[WORD_ADDR_W-1:0];
        bank_wdata = req_wdata;
        bank_we    = '0;
        if (init_busy) begin
            bank_addr  = init_cnt;
            bank_wdata = '0;
            bank_we    = '1;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_we[b] = accept && req_we && (sel == BANK_SEL_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_bank #(
            .DATA_W(DATA_W),
            .ADDR_W(WORD_ADDR_W)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we[b]),
            .addr (bank_addr),
            .wdata(bank_wdata),
            .rdata(bank_q[b])
        );
    end

    // Select and kind travel with the request so they line up with bank_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rd    <= 1'b0;
            rsp_sel   <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && !in_range;
            rsp_rd    <= accept && !req_we && in_range;
            rsp_sel   <= sel;
        end
    end

    always_comb begin
        rsp_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rsp_rd && (rsp_sel == BANK_SEL_W'(b))) begin
                rsp_rdata = bank_q[b];
            end
        end
    end

endmodule
